// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register file write arbiter: FSM state encoding,
// address/data widths and the captured write record.
// Used by: regfile_wr_arbiter, register_design.
package regfile_wr_arbiter_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int CONFLICT_CNT_W = 8;

    // FSM state encoding, kept as plain constants for compatibility with
    // older blocks that compare against raw 2-bit codes.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    // One write as captured from the winning requester.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } wr_req_t;

endpackage

// File: rtl/register_design.sv
// 16x16 register file: one write port, two combinational read ports.
// Latency: write lands on the rising edge; reads are combinational.
// Backpressure: none; every enabled write is accepted.
// Ports: clk_i, rst_i (async, clears all registers), write_en_i,
//   in_address_i, in_i, out1_address_i/out2_address_i, out1_o/out2_o.
module register_design
    import regfile_wr_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_en_i,
    input  logic [ADDR_W-1:0] in_address_i,
    input  logic [DATA_W-1:0] in_i,
    input  logic [ADDR_W-1:0] out1_address_i,
    input  logic [ADDR_W-1:0] out2_address_i,
    output logic [DATA_W-1:0] out1_o,
    output logic [DATA_W-1:0] out2_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en_i) begin
            mem_q[in_address_i] <= in_i;
        end
    end

    assign out1_o = mem_q[out1_address_i];
    assign out2_o = mem_q[out2_address_i];

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: chooses a winner among two eligible requests.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller masks ineligible requesters before this block.
// Ports: req0/req1 eligible requests, pri priority holder (0 or 1),
//        pick_vld any request present, win_idx index of the winner.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic pri,
    output logic pick_vld,
    output logic win_idx
);

    assign pick_vld = req0 | req1;

    // On a tie the priority holder wins; otherwise the only requester wins
    // (win_idx is 1 exactly when requester 1 is the sole one).
    assign win_idx = (req0 & req1) ? pri : req1;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for two writers sharing one 16x16 register file write port.
// Latency: 1 cycle from request sampling edge to the write/grant cycle.
// Backpressure: requesters hold req until their one-cycle grant pulse; the
//   granted requester is ignored on the edge closing its grant cycle.
// Ports: clk_i, rst_i (async, active-high), req/addr/data per requester,
//   gnt0_o/gnt1_o grant pulses, rf_write_en_o/rf_in_address_o/rf_In_o to the
//   register file, conflict_cnt_o (only with REGFILE_ARB_CONFLICT_CNT_EN defined).
// Option macro: REGFILE_ARB_CONFLICT_CNT_EN adds a saturating 8-bit count of
//   edges where both requesters were eligible.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rf_write_en_o,
    output logic [ADDR_W-1:0] rf_in_address_o,
    output logic [DATA_W-1:0] rf_In_o
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    ,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt_o
`endif
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       pri_q;      // 0: requester 0 wins a tie, 1: requester 1 wins
    wr_req_t    wr_q;       // write currently presented to the register file

    logic       elig0;
    logic       elig1;
    logic       pick_vld;
    logic       win_idx;

    // A requester in its grant cycle still has req high; masking it here
    // keeps that same request from being granted a second time.
    assign elig0 = req0_i & ~gnt0_o;
    assign elig1 = req1_i & ~gnt1_o;

    rr_pick2 u_pick (
        .req0     (elig0),
        .req1     (elig1),
        .pri      (pri_q),
        .pick_vld (pick_vld),
        .win_idx  (win_idx)
    );

    always_comb begin
        state_d = ST_IDLE;
        if (pick_vld) begin
            state_d = win_idx ? ST_GRANT1 : ST_GRANT0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pri_q   <= 1'b0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pick_vld) begin
                // Priority goes to whoever did not just win.
                pri_q <= ~win_idx;
                wr_q  <= win_idx ? wr_req_t'{addr: addr1_i, dat: data1_i}
                                 : wr_req_t'{addr: addr0_i, dat: data0_i};
            end
        end
    end

    // Outputs decode straight from registered state; address/data simply hold
    // their last value while idle.
    assign gnt0_o          = (state_q == ST_GRANT0);
    assign gnt1_o          = (state_q == ST_GRANT1);
    assign rf_write_en_o   = gnt0_o | gnt1_o;
    assign rf_in_address_o = wr_q.addr;
    assign rf_In_o         = wr_q.dat;

`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    logic [CONFLICT_CNT_W-1:0] conflict_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
        end else if (elig0 && elig1 && (conflict_cnt_q != {CONFLICT_CNT_W{1'b1}})) begin
            conflict_cnt_q <= conflict_cnt_q + 1'b1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter driving register_design.
module tb_regfile_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        rf_rst = 1'b0;
    logic        req0_i = 1'b0;
    logic        req1_i = 1'b0;
    logic [3:0]  addr0_i = '0;
    logic [3:0]  addr1_i = '0;
    logic [15:0] data0_i = '0;
    logic [15:0] data1_i = '0;
    logic        gnt0_o;
    logic        gnt1_o;
    logic        rf_write_en_o;
    logic [3:0]  rf_in_address_o;
    logic [15:0] rf_In_o;
    logic [3:0]  rd1_addr = '0;
    logic [3:0]  rd2_addr = '0;
    logic [15:0] out1_o;
    logic [15:0] out2_o;
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    logic [7:0]  conflict_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    regfile_wr_arbiter dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req0_i          (req0_i),
        .req1_i          (req1_i),
        .addr0_i         (addr0_i),
        .addr1_i         (addr1_i),
        .data0_i         (data0_i),
        .data1_i         (data1_i),
        .gnt0_o          (gnt0_o),
        .gnt1_o          (gnt1_o),
        .rf_write_en_o   (rf_write_en_o),
        .rf_in_address_o (rf_in_address_o),
        .rf_In_o         (rf_In_o)
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt_o  (conflict_cnt_o)
`endif
    );

    register_design u_rf (
        .clk_i          (clk_i),
        .rst_i          (rf_rst),
        .write_en_i     (rf_write_en_o),
        .in_address_i   (rf_in_address_o),
        .in_i           (rf_In_o),
        .out1_address_i (rd1_addr),
        .out2_address_i (rd2_addr),
        .out1_o         (out1_o),
        .out2_o         (out2_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic arb_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset: outputs must clear without any clock edge.
        #1;
        rst_i  = 1'b1;
        rf_rst = 1'b1;
        #1;
        chk("rst_we",   {31'd0, rf_write_en_o}, 32'd0);
        chk("rst_gnt",  {30'd0, gnt1_o, gnt0_o}, 32'd0);
        chk("rst_addr", {28'd0, rf_in_address_o}, 32'd0);
        chk("rst_data", {16'd0, rf_In_o}, 32'd0);
        tick();
        tick();
        rst_i  = 1'b0;
        rf_rst = 1'b0;

        // Single request, then input changes after the grant edge.
        req0_i = 1'b1; addr0_i = 4'd6; data0_i = 16'd25;
        tick();
        chk("s1_gnt0", {31'd0, gnt0_o}, 32'd1);
        chk("s1_gnt1", {31'd0, gnt1_o}, 32'd0);
        req0_i = 1'b0; addr0_i = 4'd15; data0_i = 16'hFFFF;
        #1;
        chk("s1_addr", {28'd0, rf_in_address_o}, 32'd6);
        chk("s1_data", {16'd0, rf_In_o}, 32'd25);
        chk("s1_we",   {31'd0, rf_write_en_o}, 32'd1);
        tick();
        rd1_addr = 4'd6;
        #1;
        chk("s1_idle_we",   {31'd0, rf_write_en_o}, 32'd0);
        chk("s1_idle_gnt0", {31'd0, gnt0_o}, 32'd0);
        chk("s1_idle_addr", {28'd0, rf_in_address_o}, 32'd6);
        chk("s1_idle_data", {16'd0, rf_In_o}, 32'd25);
        chk("s1_rd6", {16'd0, out1_o}, 32'd25);

        // Simultaneous requests after reset: requester 0 first.
        arb_reset();
        req0_i = 1'b1; addr0_i = 4'd6; data0_i = 16'd25;
        req1_i = 1'b1; addr1_i = 4'd0; data1_i = 16'd64;
        tick();
        chk("s2_c1_gnt", {30'd0, gnt1_o, gnt0_o}, 32'b01);
        chk("s2_c1_addr", {28'd0, rf_in_address_o}, 32'd6);
        req0_i = 1'b0;
        tick();
        chk("s2_c2_gnt", {30'd0, gnt1_o, gnt0_o}, 32'b10);
        chk("s2_c2_addr", {28'd0, rf_in_address_o}, 32'd0);
        chk("s2_c2_data", {16'd0, rf_In_o}, 32'd64);
        req1_i = 1'b0;
        tick();
        rd1_addr = 4'd6; rd2_addr = 4'd0;
        #1;
        chk("s2_rd6", {16'd0, out1_o}, 32'd25);
        chk("s2_rd0", {16'd0, out2_o}, 32'd64);

        // Same address: later (requester 1) write wins.
        arb_reset();
        req0_i = 1'b1; addr0_i = 4'd3; data0_i = 16'hAAAA;
        req1_i = 1'b1; addr1_i = 4'd3; data1_i = 16'h5555;
        tick();
        chk("s3_c1_data", {16'd0, rf_In_o}, 32'h0000AAAA);
        req0_i = 1'b0;
        tick();
        chk("s3_c2_data", {16'd0, rf_In_o}, 32'h00005555);
        req1_i = 1'b0;
        tick();
        rd1_addr = 4'd3;
        #1;
        chk("s3_rd3", {16'd0, out1_o}, 32'h00005555);

        // Both held for six cycles: grants alternate 0,1,0,1,0,1.
        arb_reset();
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
        chk("s4_cnt_rst", {24'd0, conflict_cnt_o}, 32'd0);
`endif
        req0_i = 1'b1; addr0_i = 4'd4; data0_i = 16'h0404;
        req1_i = 1'b1; addr1_i = 4'd5; data1_i = 16'h0505;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("s4_gnt_%0d", i), {30'd0, gnt1_o, gnt0_o},
                (i % 2 == 0) ? 32'b01 : 32'b10);
        end
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
        // Only the first edge has both eligible; afterwards one is always in its grant cycle.
        chk("s4_cnt", {24'd0, conflict_cnt_o}, 32'd1);
`endif
        req0_i = 1'b0; req1_i = 1'b0;
        tick();
        chk("s4_idle_gnt", {30'd0, gnt1_o, gnt0_o}, 32'd0);

        // Reset during GRANT1 aborts the write.
        req1_i = 1'b1; addr1_i = 4'd9; data1_i = 16'h1234;
        tick();
        chk("s5_gnt1", {31'd0, gnt1_o}, 32'd1);
        chk("s5_we",   {31'd0, rf_write_en_o}, 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("s5_abort_we",   {31'd0, rf_write_en_o}, 32'd0);
        chk("s5_abort_gnt",  {30'd0, gnt1_o, gnt0_o}, 32'd0);
        chk("s5_abort_data", {16'd0, rf_In_o}, 32'd0);
        req1_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        rd1_addr = 4'd9;
        #1;
        chk("s5_no_regrant", {30'd0, gnt1_o, gnt0_o}, 32'd0);
        chk("s5_rd9", {16'd0, out1_o}, 32'd0);
        req0_i = 1'b1; addr0_i = 4'd10; data0_i = 16'h0A0A;
        req1_i = 1'b1; addr1_i = 4'd11; data1_i = 16'h0B0B;
        tick();
        chk("s5_post_gnt", {30'd0, gnt1_o, gnt0_o}, 32'b01);
        req0_i = 1'b0;
        tick();
        chk("s5_post_gnt2", {30'd0, gnt1_o, gnt0_o}, 32'b10);
        req1_i = 1'b0;
        tick();

        // Request held one cycle past its grant: no second grant.
        req0_i = 1'b1; addr0_i = 4'd12; data0_i = 16'h00C0;
        tick();
        chk("s6_gnt", {31'd0, gnt0_o}, 32'd1);
        tick();
        chk("s6_no_second_gnt", {31'd0, gnt0_o}, 32'd0);
        chk("s6_no_second_we",  {31'd0, rf_write_en_o}, 32'd0);
        req0_i = 1'b0;
        tick();
        rd1_addr = 4'd12;
        #1;
        chk("s6_idle_gnt", {31'd0, gnt0_o}, 32'd0);
        chk("s6_rd12", {16'd0, out1_o}, 32'h000000C0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 req0_i / req1_i  input  1 each  write request from requester 0 / 1; held high until the matching grant is seen.
REQ-005 addr0_i / addr1_i  input  4 each  target register address (0-15) of requester 0 / 1.
REQ-006 data0_i / data1_i  input  16 each  write data of requester 0 / 1.
REQ-007 gnt0_o / gnt1_o  output  1 each  one-cycle grant pulse; high in the same cycle the write is presented to the register file.
REQ-008 rf_write_en_o  output  1  write enable to the 16x16 register file write port.
REQ-009 rf_in_address_o  output  4  register file write address.
REQ-010 rf_In_o  output  16  register file write data.

Function
REQ-011 The FSM SHALL have states IDLE, GRANT0 and GRANT1; outputs are registered and decoded from state plus the captured address and data registers.
REQ-012 Requests sampled at rising edge N SHALL produce the register file write (rf_write_en_o=1, address, data, gntX_o=1) during cycle N+1; latency is 1 cycle.
REQ-013 Exactly one write SHALL issue per cycle; gnt0_o and gnt1_o SHALL never be high together.
REQ-014 Transitions: from any state, if exactly one eligible request is high, go to the matching GRANTx; if both are high, go to GRANTx for x = the round-robin priority holder; if none, go to IDLE.
REQ-015 The round-robin priority SHALL pass to the other requester after every grant; after reset requester 0 holds priority.
REQ-016 A requester whose gnt is high in the current cycle SHALL be ineligible at that edge, so a req still high in the grant cycle is not granted twice.
REQ-017 Address and data SHALL be captured from the winning requester at the granting edge; later changes on the inputs do not affect the issued write.
REQ-018 Both requesters targeting the same address SHALL be serialised in round-robin order; the later write wins in the register file.
REQ-019 In IDLE, rf_write_en_o, gnt0_o and gnt1_o SHALL be 0, and rf_in_address_o and rf_In_o SHALL hold their last values.
REQ-020 With both requests held continuously, grants SHALL alternate every cycle; the worst-case wait for any requester is 2 cycles.

Reset
REQ-021 While rst_i is high: state is IDLE, all outputs are 0 and priority goes to requester 0, asynchronously, without waiting for a clock edge.
REQ-022 A reset asserted during GRANTx SHALL abort that write immediately: rf_write_en_o drops in the same cycle and no grant is reissued after reset.
REQ-023 On the first edge after rst_i falls, requests SHALL be arbitrated normally.

Configuration
REQ-024 Macro REGFILE_ARB_CONFLICT_CNT_EN: when defined, an 8-bit output conflict_cnt_o SHALL be added; it increments on every edge where both requests are eligible, saturates at 255, and resets to 0.
REQ-025 Without REGFILE_ARB_CONFLICT_CNT_EN, the port and the counter SHALL not exist, and all other behaviour is identical.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2), the address width 4 and the data width 16.
REQ-027 The round-robin pick logic SHALL be one sub-module, rr_pick2 (inputs: two eligible requests plus the priority bit; outputs: a valid flag and a winner index).

Verification
REQ-028 The bench SHALL instantiate the arbiter driving register_design, read back through out1_o and out2_o, and cover the scenarios below.
REQ-029 Single request: req0_i=1, addr0_i=6, data0_i=25 -> gnt0_o pulses 1 cycle later, and out1_o at address 6 reads 25 on the next cycle.
REQ-030 Simultaneous requests after reset, with req0 at addr 6 data 25 and req1 at addr 0 data 64 -> gnt0 then gnt1 on consecutive cycles; addr 6 reads 25 and addr 0 reads 64.
REQ-031 Same address: both requests target addr 3, with req0 data 16'hAAAA and req1 data 16'h5555, priority at requester 0 -> addr 3 finally reads 16'h5555.
REQ-032 Both requests held for 6 cycles -> grant sequence 0,1,0,1,0,1; with the macro defined, conflict_cnt_o counts every eligible-conflict edge.
REQ-033 Reset asserted in GRANT1 -> rf_write_en_o=0 immediately and the target register is unchanged; after release, requester 0 wins a simultaneous request.
REQ-034 Requester holds req for one extra cycle after its grant -> no second grant is issued for that requester.
